product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter N_TERMS, default 4: number of 6-bit products summed per result, legal range 2..255.
REQ-002 SHALL have parameter ACC_W, default 12: accumulator and result width, legal range 6..32.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clr  input  1  synchronous abort and clear of the accumulation in progress.
REQ-006 SHALL have port in_valid  input  1  in_p holds a valid product.
REQ-007 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-008 SHALL have port in_p  input  6  unsigned product from the upstream 3x3 multiplier stage, 0..49.
REQ-009 SHALL have port out_valid  output  1  out_sum and out_ovf are valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-011 SHALL have port out_sum  output  ACC_W  accumulated result.
REQ-012 SHALL have port out_ovf  output  1  result exceeded 2^ACC_W-1 during accumulation.

Function
REQ-013 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD and while clr=1.
REQ-015 SHALL accept a product exactly when in_valid&in_ready, adding zero-extended in_p to the accumulator.
REQ-016 SHALL track accepted terms with a counter: IDLE->ACCUM on the first accept; count increments per accept.
REQ-017 SHALL enter HOLD on the clock edge of the N_TERMS-th accept, with out_valid=1 from the next cycle; this gives 1-cycle latency after the final accept.
REQ-018 SHALL hold out_sum and out_ovf stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on out_valid&out_ready, go to IDLE, clear the accumulator, the counter and out_ovf, and drop out_valid on the next cycle.
REQ-020 SHALL not bypass out_ready to in_ready; the earliest next accept is the cycle after the handshake.
REQ-021 SHALL give clr priority over accept and handshake: the next state is IDLE, accumulator, counter and out_ovf are 0, out_valid is 0, and the in_p presented in the clr cycle is discarded.
REQ-022 SHALL set out_ovf when any addition carries beyond ACC_W bits; out_ovf stays sticky until the handshake, clr or rst.
REQ-023 SHALL leave state unchanged in ACCUM cycles with in_valid=0; there is no timeout.
REQ-024 SHALL drive out_sum directly from the accumulator register, with no combinational path from in_p to any output.

Reset
REQ-025 SHALL, while rst=1, immediately force state=IDLE, accumulator=0, counter=0, out_valid=0, out_sum=0 and out_ovf=0; in_ready=0 while rst=1.
REQ-026 SHALL, on rst asserted mid-accumulation or in HOLD, discard the partial or held result with no output handshake.
REQ-027 SHALL make in_ready=1 on the first clock edge after rst deasserts.

Configuration
REQ-028 SHALL use the macro ACC_SATURATE_EN to select overflow behaviour.
REQ-029 SHALL, when ACC_SATURATE_EN is defined, clamp the accumulator at 2^ACC_W-1 on overflow and hold it there for the remaining terms.
REQ-030 SHALL, when ACC_SATURATE_EN is undefined, wrap the accumulator modulo 2^ACC_W on overflow; out_ovf is set in both builds.

Verification
REQ-031 SHALL cover: defaults, accept 7,12,49,0 with out_ready=1 -> out_valid rises 1 cycle after 4th accept, out_sum=68, out_ovf=0.
REQ-032 SHALL cover: same stream with out_ready=0 for 5 cycles -> out_sum=68 held, in_ready=0 throughout, handshake then in_ready=1 next cycle.
REQ-033 SHALL cover: accept 49,49 then clr with in_valid=1, in_p=5 -> 5 discarded, next 4 accepts 1,1,1,1 -> out_sum=4.
REQ-034 SHALL cover: ACC_W=6, N_TERMS=2, inputs 49,49 -> out_ovf=1; out_sum=63 with ACC_SATURATE_EN, 34 without.
REQ-035 SHALL cover: rst pulse after 2 accepts, asynchronous to clk -> outputs 0 immediately; next 4 accepts 2,2,2,2 -> out_sum=8.
REQ-036 SHALL cover: in_valid toggling 1,0,0,1,1,0,1 with values 3,x,x,3,3,x,3 -> out_sum=12, bubbles ignored.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned 6-bit products into an ACC_W-bit result behind valid/ready handshakes.
// Define ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping it.
module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf;
    logic             valid_q;
    logic             ready_en;
    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_next;

    // ready_en keeps in_ready low until the first clock edge after reset releases
    assign in_ready  = ready_en && !clr && (state != HOLD);
    assign accept    = in_valid && in_ready;
    assign sum_ext   = {1'b0, acc} + {{(ACC_W-5){1'b0}}, in_p};
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_valid = valid_q;

`ifdef ACC_SATURATE_EN
    assign acc_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    // clr outranks both accept and the output handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            valid_q  <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (clr) begin
                state   <= IDLE;
                acc     <= '0;
                cnt     <= '0;
                ovf     <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                case (state)
                    IDLE, ACCUM: begin
                        if (accept) begin
                            acc <= acc_next;
                            ovf <= ovf | sum_ext[ACC_W];
                            cnt <= cnt + 8'd1;
                            if (cnt == LAST_CNT) begin
                                state   <= HOLD;
                                valid_q <= 1'b1;
                            end else begin
                                state <= ACCUM;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state   <= IDLE;
                            acc     <= '0;
                            cnt     <= '0;
                            ovf     <= 1'b0;
                            valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed vector table, reset/overflow sequences
// and randomized traffic against an arithmetic reference model.
module tb_product_accumulator;

    localparam int N_TERMS = 4;
    localparam int ACC_W   = 12;
    localparam int S_TERMS = 2;
    localparam int S_W     = 6;
`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk, rst, clr, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [5:0]       in_p;
    logic [ACC_W-1:0] out_sum;
    logic             s_clr, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ovf;
    logic [5:0]       s_in_p;
    logic [S_W-1:0]   s_out_sum;

    int checks;
    int errors;

    typedef struct {
        bit clr; bit v; int p; bit ordy;
        bit e_rdy; bit e_val; int e_sum; bit e_ovf;
    } vec_t;

    typedef struct { int sum; bit ovf; int cnt; bit hold; } model_t;

    vec_t vecs[$];

    product_accumulator #(.N_TERMS(N_TERMS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_p(in_p), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    product_accumulator #(.N_TERMS(S_TERMS), .ACC_W(S_W)) dut_small (
        .clk(clk), .rst(rst), .clr(s_clr), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_p(s_in_p), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_ovf(s_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit c, input bit v, input int p, input bit o);
        clr       = c;
        in_valid  = v;
        in_p      = 6'(p);
        out_ready = o;
    endtask

    task automatic addVec(input bit c, input bit v, input int p, input bit o,
                          input bit er, input bit ev, input int es, input bit eo);
        vec_t t;
        t.clr = c; t.v = v; t.p = p; t.ordy = o;
        t.e_rdy = er; t.e_val = ev; t.e_sum = es; t.e_ovf = eo;
        vecs.push_back(t);
    endtask

    // Reference: a result is the running sum of accepted terms, wrapped or clamped at 2^w-1
    function automatic model_t modelStep(input model_t m, input bit c, input bit v, input int p,
                                         input bit o, input int n, input int w);
        model_t r;
        int top;
        r = m;
        top = (1 << w) - 1;
        if (c || (m.hold && o)) begin
            r.sum = 0; r.ovf = 1'b0; r.cnt = 0; r.hold = 1'b0;
        end else if (!m.hold && v) begin
            r.sum = m.sum + p;
            if (r.sum > top) begin
                r.ovf = 1'b1;
                r.sum = SAT ? top : r.sum - (top + 1);
            end
            r.cnt = m.cnt + 1;
            if (r.cnt == n) r.hold = 1'b1;
        end
        return r;
    endfunction

    initial begin
        model_t mm, ms;
        bit rc, rv, ro, sc, sv, so;
        int rp, sp;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        s_clr = 0; s_in_valid = 0; s_in_p = 0; s_out_ready = 0;

        #2;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_sum", out_sum, 0);
        checkOutput("reset_out_ovf", out_ovf, 0);
        @(posedge clk);
        #6 rst = 1'b0;
        #1 checkOutput("release_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        checkOutput("release_in_ready_high", in_ready, 1);
        checkOutput("release_small_ready", s_in_ready, 1);

        // basic stream with out_ready=1
        addVec(0,1, 7,1, 1,0, 0,0);
        addVec(0,1,12,1, 1,0, 7,0);
        addVec(0,1,49,1, 1,0,19,0);
        addVec(0,1, 0,1, 1,0,68,0);
        addVec(0,0, 0,1, 0,1,68,0);
        addVec(0,0, 0,0, 1,0, 0,0);
        // same stream, downstream stalls 5 cycles while upstream keeps pushing
        addVec(0,1, 7,0, 1,0, 0,0);
        addVec(0,1,12,0, 1,0, 7,0);
        addVec(0,1,49,0, 1,0,19,0);
        addVec(0,1, 0,0, 1,0,68,0);
        for (int i = 0; i < 5; i++) addVec(0,1,5,0, 0,1,68,0);
        addVec(0,0, 0,1, 0,1,68,0);
        addVec(0,0, 0,0, 1,0, 0,0);
        // bubbles
        addVec(0,1, 3,0, 1,0, 0,0);
        addVec(0,0, 9,0, 1,0, 3,0);
        addVec(0,0, 9,0, 1,0, 3,0);
        addVec(0,1, 3,0, 1,0, 3,0);
        addVec(0,1, 3,0, 1,0, 6,0);
        addVec(0,0, 9,0, 1,0, 9,0);
        addVec(0,1, 3,1, 1,0, 9,0);
        addVec(0,0, 0,1, 0,1,12,0);
        addVec(0,0, 0,0, 1,0, 0,0);
        // clr mid-accumulation discards the presented term
        addVec(0,1,49,0, 1,0, 0,0);
        addVec(0,1,49,0, 1,0,49,0);
        addVec(1,1, 5,0, 0,0,98,0);
        addVec(0,1, 1,0, 1,0, 0,0);
        addVec(0,1, 1,0, 1,0, 1,0);
        addVec(0,1, 1,0, 1,0, 2,0);
        addVec(0,1, 1,1, 1,0, 3,0);
        addVec(0,0, 0,1, 0,1, 4,0);
        addVec(0,0, 0,0, 1,0, 0,0);
        // clr in HOLD beats the handshake
        addVec(0,1,10,0, 1,0, 0,0);
        addVec(0,1,10,0, 1,0,10,0);
        addVec(0,1,10,0, 1,0,20,0);
        addVec(0,1,10,0, 1,0,30,0);
        addVec(1,0, 0,1, 0,1,40,0);
        addVec(0,0, 0,0, 1,0, 0,0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clr, vecs[i].v, vecs[i].p, vecs[i].ordy);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
            checkOutput($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_val);
            checkOutput($sformatf("vec%0d_out_sum", i), out_sum, vecs[i].e_sum);
            checkOutput($sformatf("vec%0d_out_ovf", i), out_ovf, vecs[i].e_ovf);
            @(posedge clk); #1;
        end

        // asynchronous reset after two accepts
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 2, 0);
            @(posedge clk); #1;
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("pre_rst_sum", out_sum, 4);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_sum", out_sum, 0);
        checkOutput("async_rst_ready", in_ready, 0);
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_ovf", out_ovf, 0);
        @(posedge clk); #1;
        checkOutput("rst_held_sum", out_sum, 0);
        #3 rst = 1'b0;
        #1 checkOutput("rst_release_ready_low", in_ready, 0);
        @(posedge clk); #1;
        checkOutput("rst_release_ready_high", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 2, 1);
            @(posedge clk); #1;
        end
        applyStimulus(0, 0, 0, 1);
        checkOutput("post_rst_valid", out_valid, 1);
        checkOutput("post_rst_sum", out_sum, 8);
        checkOutput("post_rst_ready", in_ready, 0);
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("post_rst_valid_drop", out_valid, 0);
        checkOutput("post_rst_ready_back", in_ready, 1);

        // overflow on the narrow instance
        s_in_valid = 1; s_in_p = 6'd49; s_out_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_in_valid = 0;
        checkOutput("ovf_valid", s_out_valid, 1);
        checkOutput("ovf_sum", s_out_sum, SAT ? 63 : 34);
        checkOutput("ovf_flag", s_out_ovf, 1);
        checkOutput("ovf_ready", s_in_ready, 0);
        @(posedge clk); #1;
        checkOutput("ovf_sum_held", s_out_sum, SAT ? 63 : 34);
        checkOutput("ovf_flag_held", s_out_ovf, 1);
        s_out_ready = 1;
        @(posedge clk); #1;
        s_out_ready = 0;
        checkOutput("ovf_valid_drop", s_out_valid, 0);
        checkOutput("ovf_flag_clear", s_out_ovf, 0);
        checkOutput("ovf_sum_clear", s_out_sum, 0);
        checkOutput("ovf_ready_back", s_in_ready, 1);

        // randomized traffic on both instances
        mm = '{0, 1'b0, 0, 1'b0};
        ms = '{0, 1'b0, 0, 1'b0};
        for (int i = 0; i < 400; i++) begin
            rc = ($urandom_range(0, 31) == 0);
            rv = 1'($urandom_range(0, 1));
            rp = $urandom_range(0, 49);
            ro = 1'($urandom_range(0, 1));
            sc = ($urandom_range(0, 31) == 0);
            sv = 1'($urandom_range(0, 1));
            sp = $urandom_range(0, 49);
            so = 1'($urandom_range(0, 1));
            applyStimulus(rc, rv, rp, ro);
            s_clr = sc; s_in_valid = sv; s_in_p = 6'(sp); s_out_ready = so;
            @(negedge clk);
            checkOutput("rnd_in_ready", in_ready, int'(!rc && !mm.hold));
            checkOutput("rnd_out_valid", out_valid, int'(mm.hold));
            checkOutput("rnd_out_sum", out_sum, mm.sum);
            checkOutput("rnd_out_ovf", out_ovf, int'(mm.ovf));
            checkOutput("rnd_s_in_ready", s_in_ready, int'(!sc && !ms.hold));
            checkOutput("rnd_s_out_valid", s_out_valid, int'(ms.hold));
            checkOutput("rnd_s_out_sum", s_out_sum, ms.sum);
            checkOutput("rnd_s_out_ovf", s_out_ovf, int'(ms.ovf));
            mm = modelStep(mm, rc, rv, rp, ro, N_TERMS, ACC_W);
            ms = modelStep(ms, sc, sv, sp, so, S_TERMS, S_W);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
